// File: rtl/fft_result_reader.sv
// Captures one FFT result frame from the core's wd port into a local buffer,
// then re-streams the bins over valid/ready with |X|^2 attached.
module fft_result_reader #(
    parameter int width = 16,
    parameter int N_2   = 5,
    parameter int HALF  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 done,
    input  logic [2*width-1:0]   wd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*width-1:0]   out_data,
    output logic [2*width-1:0]   out_mag,
    output logic [N_2-1:0]       out_bin,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_abort,
    output logic                 err_ovf
);

    localparam int N = 2**N_2;
    localparam int LAST = (HALF != 0) ? (N/2 - 1) : (N - 1);
    localparam logic [N_2-1:0] LAST_IDX = LAST[N_2-1:0];

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic                 done_q_reg;
    logic [N_2-1:0]       cap_idx_reg, cap_idx_next;
    logic [N_2-1:0]       rd_idx_reg, rd_idx_next;
    logic                 out_valid_reg;
    logic [2*width-1:0]   out_data_reg;
    logic [2*width-1:0]   out_mag_reg;
    logic [N_2-1:0]       out_bin_reg;
    logic                 out_last_reg;
    logic                 err_abort_reg;
    logic                 err_ovf_reg;

    logic                 rise;
    logic                 cap_wr;
    logic [N_2-1:0]       wr_addr;
    logic                 load;
    logic                 finish;
    logic                 abort_set;
    logic                 ovf_set;

    logic [2*width-1:0]   buf_mem [N];
    logic [2*width-1:0]   rd_word;
    logic [2*width-1:0]   re_ext, im_ext;
    logic [2*width-1:0]   re_sq, im_sq, mag_next;

    assign rise = done & ~done_q_reg;

    // Products are taken modulo 2**(2*width); the true sum never exceeds 2**(2*width-1).
    assign rd_word  = buf_mem[rd_idx_reg];
    assign re_ext   = {{width{rd_word[2*width-1]}}, rd_word[2*width-1:width]};
    assign im_ext   = {{width{rd_word[width-1]}}, rd_word[width-1:0]};
    assign re_sq    = re_ext * re_ext;
    assign im_sq    = im_ext * im_ext;
    assign mag_next = re_sq + im_sq;

    always_comb begin
        state_next   = state_reg;
        cap_idx_next = cap_idx_reg;
        rd_idx_next  = rd_idx_reg;
        wr_addr      = cap_idx_reg;
        cap_wr       = 1'b0;
        load         = 1'b0;
        finish       = 1'b0;
        abort_set    = 1'b0;
        ovf_set      = 1'b0;
        case (state_reg)
            IDLE: begin
                rd_idx_next = '0;
                if (rise) begin
                    cap_wr       = 1'b1;
                    wr_addr      = '0;
                    cap_idx_next = N_2'(1);
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                ovf_set = rise;
                if (done) begin
                    cap_wr       = 1'b1;
                    cap_idx_next = cap_idx_reg + N_2'(1);
                    if (cap_idx_reg == '1)
                        state_next = DRAIN;
                end else begin
                    abort_set    = 1'b1;
                    cap_idx_next = '0;
                    state_next   = IDLE;
                end
            end
            DRAIN: begin
                ovf_set = rise;
                if (out_valid_reg && out_ready && out_last_reg) begin
                    finish      = 1'b1;
                    rd_idx_next = '0;
                    state_next  = IDLE;
                // Refill the output register whenever it is empty or being consumed.
                end else if (!(out_valid_reg && out_last_reg) && (!out_valid_reg || out_ready)) begin
                    load        = 1'b1;
                    rd_idx_next = rd_idx_reg + N_2'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cap_wr)
            buf_mem[wr_addr] <= wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            done_q_reg    <= 1'b0;
            cap_idx_reg   <= '0;
            rd_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_mag_reg   <= '0;
            out_bin_reg   <= '0;
            out_last_reg  <= 1'b0;
            err_abort_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            done_q_reg  <= done;
            cap_idx_reg <= cap_idx_next;
            rd_idx_reg  <= rd_idx_next;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= rd_word;
                out_mag_reg   <= mag_next;
                out_bin_reg   <= rd_idx_reg;
                out_last_reg  <= (rd_idx_reg == LAST_IDX);
            end else if (finish) begin
                out_valid_reg <= 1'b0;
            end
            if (abort_set)
                err_abort_reg <= 1'b1;
            if (ovf_set)
                err_ovf_reg <= 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_mag   = out_mag_reg;
    assign out_bin   = out_bin_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);
    assign err_abort = err_abort_reg;
    assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: full-spectrum instance plus a HALF=1 instance.
module tb_fft_result_reader;

    localparam int W  = 16;
    localparam int NB = 5;
    localparam int N  = 32;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mag;
        logic [4:0]  bin;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done = 1'b0;
    logic        done_h = 1'b0;
    logic [31:0] wd = '0;
    logic        out_ready = 1'b1;
    logic        ready_h = 1'b1;

    logic        out_valid, out_last, busy, err_abort, err_ovf;
    logic [31:0] out_data, out_mag;
    logic [4:0]  out_bin;
    logic        out_valid_h, out_last_h, busy_h, err_abort_h, err_ovf_h;
    logic [31:0] out_data_h, out_mag_h;
    logic [4:0]  out_bin_h;

    fft_result_reader #(.width(W), .N_2(NB), .HALF(0)) u_dut (
        .clk(clk), .reset(reset), .done(done), .wd(wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mag(out_mag), .out_bin(out_bin), .out_last(out_last),
        .busy(busy), .err_abort(err_abort), .err_ovf(err_ovf)
    );

    fft_result_reader #(.width(W), .N_2(NB), .HALF(1)) u_half (
        .clk(clk), .reset(reset), .done(done_h), .wd(wd),
        .out_valid(out_valid_h), .out_ready(ready_h), .out_data(out_data_h),
        .out_mag(out_mag_h), .out_bin(out_bin_h), .out_last(out_last_h),
        .busy(busy_h), .err_abort(err_abort_h), .err_ovf(err_ovf_h)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rpat = 0;
    int   rcnt = 0;
    int   drive_cyc = 0;
    int   first_cyc = 0;
    bit   seen_first = 1'b0;
    exp_t q[$];
    exp_t qh[$];
    exp_t e_m, e_h;
    bit   stall_prev = 1'b0;
    logic [31:0] h_data, h_mag;
    logic [4:0]  h_bin;
    logic        h_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] make_word(input int mode, input int k);
        logic [15:0] kk;
        kk = k[15:0];
        if (mode == 1 && k == 0) return {16'h8000, 16'h8000};
        if (mode == 1 && k == 1) return {16'h7fff, 16'h0000};
        if (mode == 2) return $urandom;
        return {kk, -kk};
    endfunction

    function automatic logic [31:0] model_mag(input logic [31:0] w);
        longint re_l, im_l, m;
        re_l = longint'($signed(w[31:16]));
        im_l = longint'($signed(w[15:0]));
        m = re_l * re_l + im_l * im_l;
        return m[31:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rcnt++;
        case (rpat)
            1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Full-spectrum instance monitor: ordering, content and stall stability.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, h_data);
                check_val("hold_mag", out_mag, h_mag);
                check_val("hold_bin", out_bin, h_bin);
                check_val("hold_last", out_last, h_last);
            end
            stall_prev = 1'b0;
            if (out_valid) begin
                if (!seen_first) begin
                    first_cyc  = cyc;
                    seen_first = 1'b1;
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        check_val("extra_beat", 1, 0);
                    end else begin
                        e_m = q.pop_front();
                        check_val("data", out_data, e_m.data);
                        check_val("mag", out_mag, e_m.mag);
                        check_val("bin", out_bin, e_m.bin);
                        check_val("last", out_last, e_m.last);
                        $display("beat bin=%0d data=%08h mag=%08h last=%0b", out_bin, out_data, out_mag, out_last);
                    end
                end else begin
                    stall_prev = 1'b1;
                    h_data = out_data;
                    h_mag  = out_mag;
                    h_bin  = out_bin;
                    h_last = out_last;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && out_valid_h) begin
            if (qh.size() == 0) begin
                check_val("half_extra_beat", 1, 0);
            end else begin
                e_h = qh.pop_front();
                check_val("half_data", out_data_h, e_h.data);
                check_val("half_mag", out_mag_h, e_h.mag);
                check_val("half_bin", out_bin_h, e_h.bin);
                check_val("half_last", out_last_h, e_h.last);
                $display("half beat bin=%0d data=%08h last=%0b", out_bin_h, out_data_h, out_last_h);
            end
        end
    end

    task automatic send_frame(input int nw, input int mode, input bit to_full, input bit to_half);
        logic [31:0] w;
        exp_t e;
        for (int k = 0; k < nw; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) drive_cyc = cyc;
            w = make_word(mode, k);
            wd = w;
            if (to_full) done = 1'b1;
            if (to_half) done_h = 1'b1;
            if (nw == N) begin
                e.data = w;
                e.mag  = model_mag(w);
                if (mode == 1 && k == 0) e.mag = 32'h8000_0000;
                if (mode == 1 && k == 1) e.mag = 32'h3fff_0001;
                e.bin  = k[4:0];
                e.last = (k == N - 1);
                if (to_full) q.push_back(e);
                e.last = (k == N/2 - 1);
                if (to_half && k < N/2) qh.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        done = 1'b0;
        done_h = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (q.size() == 0 && qh.size() == 0 && !busy && !busy_h) break;
        end
        check_val({tag, "_q_empty"}, q.size(), 0);
        check_val({tag, "_qh_empty"}, qh.size(), 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_valid"}, out_valid, 0);
        $display("frame %s drained at cyc %0d", tag, cyc);
    endtask

    initial begin
        int found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_abort", err_abort, 0);
        check_val("rst_ovf", err_ovf, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_mag", out_mag, 0);
        check_val("rst_last", out_last, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full rate frame plus first-beat latency.
        rpat = 0;
        seen_first = 1'b0;
        send_frame(N, 0, 1'b1, 1'b0);
        wait_drain("full_rate");
        check_val("latency", first_cyc - drive_cyc, N + 1);

        // Stalled handshake, 1,0,0,1 pattern.
        rpat = 1;
        send_frame(N, 0, 1'b1, 1'b0);
        wait_drain("stall");

        // HALF instance only.
        rpat = 0;
        send_frame(N, 0, 1'b0, 1'b1);
        wait_drain("half");
        check_val("half_busy", busy_h, 0);

        // Extreme values with random backpressure, then a random frame.
        rpat = 2;
        send_frame(N, 1, 1'b1, 1'b0);
        wait_drain("extreme");
        send_frame(N, 2, 1'b1, 1'b1);
        wait_drain("random");
        check_val("no_abort_yet", err_abort, 0);
        check_val("no_ovf_yet", err_ovf, 0);

        // Abort after 10 captured words, then a clean frame.
        rpat = 0;
        send_frame(10, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_val("abort_flag", err_abort, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", out_valid, 0);
        send_frame(N, 0, 1'b1, 1'b0);
        wait_drain("after_abort");
        check_val("abort_sticky", err_abort, 1);

        // Rise during DRAIN is flagged and ignored.
        rpat = 1;
        send_frame(N, 2, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_val("ovf_in_drain", busy, 1);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        wait_drain("overflow");
        check_val("ovf_flag", err_ovf, 1);

        // Reset while bin 7 is presented.
        rpat = 0;
        send_frame(N, 0, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid && out_bin == 5'd7) begin
                found = 1;
                break;
            end
        end
        check_val("bin7_seen", found, 1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_abort", err_abort, 0);
        check_val("mid_rst_ovf", err_ovf, 0);
        q.delete();
        #1;
        reset = 1'b0;
        send_frame(N, 0, 1'b1, 1'b0);
        wait_drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
